// File: rtl/amplitude_frame_writer.sv
// Serialises one WORDS-word frame per handshake into the amplitude FIFO.
// Optional FRAME_CNT_EN adds a 16-bit count of completed frames.
module amplitude_frame_writer #(
  parameter int DATA_W = 16,
  parameter int WORDS  = 6
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    frame_valid,
  output logic                    frame_ready,
  input  logic [WORDS*DATA_W-1:0] frame_data,
  input  logic                    abort,
  input  logic                    fifo_almost_full,
  output logic [DATA_W-1:0]       fifo_wdata,
  output logic                    fifo_wren,
  output logic                    busy,
  output logic                    frame_done
`ifdef FRAME_CNT_EN
  ,
  output logic [15:0]             frame_cnt
`endif
);

  localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IW-1:0] LAST = IW'(WORDS - 1);

  typedef enum logic {
    IDLE = 1'b0,
    WR   = 1'b1
  } state_t;

  state_t            state;
  logic [IW-1:0]     idx;
  logic [DATA_W-1:0] shadow [WORDS];

  assign busy = (state == WR);

  // frame_ready is registered so it stays low while reset is held
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state       <= IDLE;
      idx         <= '0;
      fifo_wren   <= 1'b0;
      fifo_wdata  <= '0;
      frame_done  <= 1'b0;
      frame_ready <= 1'b0;
      for (int k = 0; k < WORDS; k++) shadow[k] <= '0;
`ifdef FRAME_CNT_EN
      frame_cnt   <= '0;
`endif
    end else begin
      fifo_wren  <= 1'b0;
      frame_done <= 1'b0;
      unique case (state)
        IDLE: begin
          frame_ready <= 1'b1;
          if (!abort && frame_valid && frame_ready) begin
            for (int k = 0; k < WORDS; k++)
              shadow[k] <= frame_data[k*DATA_W +: DATA_W];
            idx         <= '0;
            state       <= WR;
            frame_ready <= 1'b0;
          end
        end
        WR: begin
          if (abort) begin
            idx         <= '0;
            state       <= IDLE;
            frame_ready <= 1'b1;
          end else if (!fifo_almost_full) begin
            fifo_wren  <= 1'b1;
            fifo_wdata <= shadow[idx];
            if (idx == LAST) begin
              frame_done  <= 1'b1;
              idx         <= '0;
              state       <= IDLE;
              frame_ready <= 1'b1;
`ifdef FRAME_CNT_EN
              frame_cnt   <= frame_cnt + 16'd1;
`endif
            end else begin
              idx <= idx + IW'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
